// File: rtl/sb_pkg.sv
// Shared types and constants for the ID-stage register-hazard scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sb_pkg;

    localparam int SB_CW = 3;

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_ALU  = 2'b01,
        CLS_LOAD = 2'b10,
        CLS_MUL  = 2'b11
    } cls_t;

    // ALU results are bypassed, so only load/mul ever arm a counter.
    function automatic logic [SB_CW-1:0] cls_lat(
        input logic [1:0]       cls,
        input logic [SB_CW-1:0] load_lat,
        input logic [SB_CW-1:0] mul_lat
    );
        case (cls)
            CLS_LOAD: return load_lat;
            CLS_MUL:  return mul_lat;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/sb_cnt.sv
// Per-register pending-result down-counter; load wins over decrement.
// Latency: value visible the cycle after load.
// Backpressure: none; counts down unconditionally until zero.
module sb_cnt
    import sb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic [SB_CW-1:0] ld_val_i,
    output logic [SB_CW-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (ld_i) begin
            cnt_o <= ld_val_i;
        end else if (cnt_o != '0) begin
            cnt_o <= cnt_o - 1'b1;
        end
    end

endmodule

// File: rtl/scoreboard.sv
// ID-stage register-hazard scoreboard: stalls issue on RAW/WAW against in-flight results.
// Latency: stall_o/issue_o combinational; counters update on the next edge.
// Backpressure: stall_o holds PC and IF/ID while a hazard persists; flush_i suppresses both.
module scoreboard
    import sb_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    input  logic        flush_i,
    input  logic [4:0]  rsaddr_i,
    input  logic [4:0]  rtaddr_i,
    input  logic        rt_used_i,
    input  logic [4:0]  wraddr_i,
    input  logic [1:0]  class_i,
    output logic        stall_o,
    output logic        issue_o,
    output logic        busy_o,
    output logic [15:0] stall_cnt_o
);

    localparam logic [SB_CW-1:0] LD_LAT = SB_CW'(LOAD_LAT);
    localparam logic [SB_CW-1:0] ML_LAT = SB_CW'(MUL_LAT);

    logic [SB_CW-1:0] cnt [32];
    logic [31:1]      pend;
    logic             raw_rs, raw_rt, waw, hazard, arm;
    logic [SB_CW-1:0] lat;

    // $0 is hardwired zero and never pending.
    assign cnt[0] = '0;

    for (genvar i = 1; i < 32; i++) begin : g_cnt
        sb_cnt u_cnt (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .ld_i     (arm && (wraddr_i == 5'(i))),
            .ld_val_i (lat),
            .cnt_o    (cnt[i])
        );
        assign pend[i] = (cnt[i] != '0);
    end

    assign raw_rs = (rsaddr_i != 5'd0) && (cnt[rsaddr_i] != '0);
    assign raw_rt = rt_used_i && (rtaddr_i != 5'd0) && (cnt[rtaddr_i] != '0);
    assign waw    = (class_i != CLS_NONE) && (wraddr_i != 5'd0) && (cnt[wraddr_i] != '0);
    assign hazard = raw_rs || raw_rt || waw;

    assign stall_o = issue_valid_i && !flush_i && hazard;
    assign issue_o = issue_valid_i && !flush_i && !hazard;
    assign busy_o  = |pend;

    assign lat = cls_lat(class_i, LD_LAT, ML_LAT);
    assign arm = issue_o && ((class_i == CLS_LOAD) || (class_i == CLS_MUL));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_scoreboard.sv
// Bench for scoreboard: cycle-by-cycle vector table with expected outputs queued per drive.
module tb_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i, flush_i, rt_used_i;
    logic [4:0]  rsaddr_i, rtaddr_i, wraddr_i;
    logic [1:0]  class_i;
    logic        stall_o, issue_o, busy_o;
    logic [15:0] stall_cnt_o;

    scoreboard #(.LOAD_LAT(1), .MUL_LAT(3)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .flush_i       (flush_i),
        .rsaddr_i      (rsaddr_i),
        .rtaddr_i      (rtaddr_i),
        .rt_used_i     (rt_used_i),
        .wraddr_i      (wraddr_i),
        .class_i       (class_i),
        .stall_o       (stall_o),
        .issue_o       (issue_o),
        .busy_o        (busy_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        stall;
        logic        issue;
        logic        busy;
        logic [15:0] scnt;
    } exp_t;

    typedef struct {
        logic       vld;
        logic       fl;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rtu;
        logic [4:0] wr;
        logic [1:0] cls;
        exp_t       exp;
    } vec_t;

    localparam logic [1:0] N = 2'b00, A = 2'b01, L = 2'b10, M = 2'b11;

    vec_t vt [30];
    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic vld, input logic fl, input logic [4:0] rs,
                                input logic [4:0] rt, input logic rtu, input logic [4:0] wr,
                                input logic [1:0] cls, input logic st, input logic is,
                                input logic bz, input logic [15:0] sc);
        vec_t v;
        v.vld = vld; v.fl = fl; v.rs = rs; v.rt = rt; v.rtu = rtu; v.wr = wr; v.cls = cls;
        v.exp = '{stall: st, issue: is, busy: bz, scnt: sc};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        issue_valid_i = v.vld; flush_i = v.fl; rsaddr_i = v.rs; rtaddr_i = v.rt;
        rt_used_i = v.rtu; wraddr_i = v.wr; class_i = v.cls;
        exp_q.push_back(v.exp);
    endtask

    task automatic check_out(input string name);
        exp_t e, g;
        e = exp_q.pop_front();
        g = '{stall: stall_o, issue: issue_o, busy: busy_o, scnt: stall_cnt_o};
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got stall=%b issue=%b busy=%b scnt=%0d, want stall=%b issue=%b busy=%b scnt=%0d",
                     name, g.stall, g.issue, g.busy, g.scnt, e.stall, e.issue, e.busy, e.scnt);
        end
    endtask

    initial begin
        //          vld fl rs rt rtu wr cls  st is bz scnt
        vt[0]  = mk(1, 0, 1, 0, 0, 2,  L, 0, 1, 0, 0);   // lw $2
        vt[1]  = mk(1, 0, 2, 4, 1, 3,  A, 1, 0, 1, 0);   // add $3,$2,$4 stalls
        vt[2]  = mk(1, 0, 2, 4, 1, 3,  A, 0, 1, 0, 1);
        vt[3]  = mk(1, 0, 1, 1, 1, 5,  M, 0, 1, 0, 1);   // mul $5
        vt[4]  = mk(1, 0, 1, 5, 1, 8,  A, 1, 0, 1, 1);   // reads $5 via rt
        vt[5]  = mk(1, 0, 1, 5, 1, 8,  A, 1, 0, 1, 2);
        vt[6]  = mk(1, 0, 1, 5, 1, 8,  A, 1, 0, 1, 3);
        vt[7]  = mk(1, 0, 1, 5, 1, 8,  A, 0, 1, 0, 4);
        vt[8]  = mk(1, 0, 1, 1, 1, 5,  M, 0, 1, 0, 4);   // mul $5 again
        vt[9]  = mk(1, 0, 1, 5, 0, 9,  A, 0, 1, 1, 4);   // rt not used
        vt[10] = mk(1, 0, 1, 1, 0, 6,  A, 0, 1, 1, 4);   // ALU $6
        vt[11] = mk(1, 0, 6, 6, 1, 10, A, 0, 1, 1, 4);
        vt[12] = mk(1, 0, 1, 0, 0, 0,  L, 0, 1, 0, 4);   // load $0
        vt[13] = mk(1, 0, 0, 0, 1, 11, A, 0, 1, 0, 4);
        vt[14] = mk(1, 0, 1, 1, 0, 7,  M, 0, 1, 0, 4);   // mul $7
        vt[15] = mk(1, 0, 1, 0, 0, 7,  L, 1, 0, 1, 4);   // lw $7 WAW
        vt[16] = mk(1, 0, 1, 0, 0, 7,  L, 1, 0, 1, 5);
        vt[17] = mk(1, 0, 1, 0, 0, 7,  L, 1, 0, 1, 6);
        vt[18] = mk(1, 0, 1, 0, 0, 7,  L, 0, 1, 0, 7);
        vt[19] = mk(1, 0, 7, 0, 0, 12, A, 1, 0, 1, 7);   // cnt[7] = LOAD_LAT
        vt[20] = mk(1, 0, 7, 0, 0, 12, A, 0, 1, 0, 8);
        vt[21] = mk(1, 0, 1, 1, 0, 9,  M, 0, 1, 0, 8);   // mul $9
        vt[22] = mk(1, 1, 9, 0, 0, 13, M, 0, 0, 1, 8);   // flushed hazard
        vt[23] = mk(1, 0, 9, 0, 0, 13, M, 1, 0, 1, 8);
        vt[24] = mk(1, 0, 9, 0, 0, 13, M, 1, 0, 1, 9);
        vt[25] = mk(1, 0, 9, 0, 0, 13, M, 0, 1, 0, 10);  // mul $13
        vt[26] = mk(0, 0, 13, 0, 0, 0, N, 0, 0, 1, 10);
        vt[27] = mk(0, 0, 13, 0, 0, 0, N, 0, 0, 1, 10);
        vt[28] = mk(0, 0, 13, 0, 0, 0, N, 0, 0, 1, 10);
        vt[29] = mk(0, 0, 13, 0, 0, 0, N, 0, 0, 0, 10);

        rst_i = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, N, 0, 0, 0, 0));
        #12;
        check_out("reset_idle");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int i = 0; i < 30; i++) begin
            drive(vt[i]);
            @(negedge clk_i);
            check_out($sformatf("vec%0d", i));
            @(posedge clk_i); #1;
        end

        // Reset pulsed mid-stall: mul $5, stall twice, then async reset between edges.
        drive(mk(1, 0, 1, 1, 0, 5, M, 0, 1, 0, 10));
        @(negedge clk_i); check_out("rst_seq_mul");
        @(posedge clk_i); #1;
        drive(mk(1, 0, 5, 0, 0, 14, A, 1, 0, 1, 10));
        @(negedge clk_i); check_out("rst_seq_stall0");
        @(posedge clk_i); #1;
        drive(mk(1, 0, 5, 0, 0, 14, A, 1, 0, 1, 11));
        @(negedge clk_i); check_out("rst_seq_stall1");
        #1;
        rst_i = 1'b1;
        drive(mk(1, 0, 5, 0, 0, 14, A, 0, 1, 0, 0));
        #1;
        check_out("rst_mid_stall");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive(mk(1, 0, 5, 0, 0, 14, A, 0, 1, 0, 0));
        @(negedge clk_i); check_out("post_rst_issue");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
